// File: rtl/dmem_responder.sv
// Single-port word memory answering one load/store at a time after a fixed
// number of wait states; faulting accesses answer early with err and touch nothing.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  WAIT_W  = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            accept;
  logic            fault_in;

  logic            lat_we;
  logic            lat_fault;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;

  logic [31:0]     mem [DEPTH];

  assign fault_in = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_W);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (fault_in || WAIT == 0) begin
            cnt_next   = 4'd0;
            state_next = ST_RESP;
          end else begin
            cnt_next   = WAIT_W;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - 4'd1;
        // Leaving on the 1->0 step gives exactly WAIT cycles in this state.
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_fault <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= we;
        lat_fault <= fault_in;
        lat_idx   <= addr[AW+1:2];
        lat_wdata <= wdata;
        lat_be    <= be;
      end
    end
  end

  // Memory has no reset; a reset during RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && state == ST_RESP && lat_we && !lat_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  assign ready = (state == ST_RESP);
  assign busy  = (state != ST_IDLE);
  assign err   = ready && lat_fault;
  assign rdata = (ready && !lat_we && !lat_fault) ? mem[lat_idx] : 32'd0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 256, number of 32-bit words stored (power of 2, 16..1024)
- WAIT, 2, wait-state cycles between request acceptance and response (0..15)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, synchronous, active-high
- req, in, 1, request valid, level, held by initiator until ready
- we, in, 1, 1 = store, 0 = load
- addr, in, 32, byte address
- wdata, in, 32, store data
- be, in, 4, byte enables; be[i] selects wdata[8i+7:8i]
- ready, out, 1, one-cycle response strobe
- rdata, out, 32, load data, valid when ready=1
- err, out, 1, access fault, valid when ready=1
- busy, out, 1, high from acceptance until ready cycle inclusive

REQ-003 The block SHALL use one clock, clk, and a synchronous active-high reset, reset.

Function
REQ-004 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-005 In IDLE with req=1, the block SHALL latch we, addr, wdata, and be, load the wait counter with WAIT, and leave IDLE at the same edge.
REQ-006 Leaving IDLE, the next state SHALL be WAIT if WAIT>0, else RESP.
REQ-007 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL enter RESP on the edge where the counter goes 1->0.
REQ-008 RESP SHALL last exactly one cycle, with ready=1, then return to IDLE.
REQ-009 Latency: for a request accepted at edge N, ready SHALL be high during cycle N+WAIT+1.
REQ-010 Fault conditions are addr[1:0]!=0, or word index addr[31:2] >= DEPTH.
- A faulting request SHALL skip WAIT, enter RESP directly, and assert err=1 with rdata=0.
- A faulting request SHALL leave memory unmodified.
REQ-011 Load: rdata SHALL equal mem[addr[31:2]] as stored before the response cycle; err=0.
REQ-012 Store: on the edge ending RESP, the block SHALL write only the bytes where be=1; rdata SHALL be 0 and err=0.
REQ-013 A store with be=4'b0000 SHALL complete normally without changing memory.
REQ-014 req SHALL be ignored in WAIT and RESP, and input changes there SHALL NOT affect the transaction in flight.
REQ-015 If req is still high in the IDLE cycle after RESP, that cycle SHALL accept a new transaction; the minimum spacing of ready pulses is WAIT+2 cycles.
REQ-016 Outside the RESP cycle, ready=0, err=0, and rdata=0.
REQ-017 A load immediately following a store to the same word SHALL return the merged stored value.

Reset
REQ-018 With reset=1 at a rising edge, the block SHALL set state=IDLE, counter=0, ready=0, err=0, rdata=0, busy=0.
REQ-019 Reset SHALL take priority over every other event, including a simultaneous req.
REQ-020 Reset in WAIT or RESP SHALL abort the transaction.
- A pending store SHALL be discarded.
- No ready pulse SHALL follow the reset.
REQ-021 Memory contents SHALL NOT be cleared by reset.

Verification (WAIT=2, DEPTH=256)
REQ-022 Store then load:
- Stimulus: store addr=0x10, wdata=0xDEADBEEF, be=4'hF, accepted at edge N.
- Required: ready in cycle N+3.
- Then: load 0x10 returns rdata=0xDEADBEEF, err=0.
REQ-023 Byte-enable merge:
- Stimulus: preload word 0x20 = 0x11223344; store wdata=0xAABBCCDD, be=4'b0101.
- Required: load of 0x20 returns 0x11BB33DD.
REQ-024 Faults:
- Stimulus: load addr=0x02, and separately store addr=0x400.
- Required: ready one cycle after acceptance, err=1, rdata=0.
- Required: memory at word 0 unchanged.
REQ-025 Back-to-back:
- Stimulus: hold req=1 with we=0 for 12 cycles.
- Required: ready pulses every 4 cycles.
- Required: busy low only in each IDLE acceptance cycle.
REQ-026 Reset mid-operation:
- Stimulus: store 0x55555555 to 0x30, reset asserted in WAIT.
- Required: no ready pulse; all outputs 0 the cycle after reset.
- Required: later load of 0x30 returns its prior value.
REQ-027 WAIT=0 build:
- Stimulus: load accepted at edge N.
- Required: ready in cycle N+1; ready pulses every 2 cycles under continuous req.
